// File: rtl/vga_ports.sv
// CPU-facing VGA I/O register stage: DAC palette, CRTC cursor/mode and input status ports.
// Latency: every register output, including port_out, updates one clock after the accepted strobe.
// Backpressure: port_ready drops for 2 cycles during a palette fetch; strobes seen while it is low are dropped.
module vga_ports #(
  parameter logic [5:0] CURSOR_LO_RST = 6'd14,
  parameter logic [4:0] CURSOR_HI_RST = 5'd15,
  parameter logic [7:0] MODE_INDEX    = 8'h30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] port_addr,
  input  logic [7:0]  port_in,
  input  logic        port_write,
  input  logic        port_read,
  output logic [7:0]  port_out,
  output logic        port_ready,
  input  logic        hs,
  input  logic        vs,
  output logic        dac_we,
  output logic [7:0]  dac_addr,
  output logic [31:0] dac_wd,
  input  logic [31:0] dac_rd,
  output logic [10:0] cursor,
  output logic [5:0]  cursor_shape_lo,
  output logic [4:0]  cursor_shape_hi,
  output logic [1:0]  videomode
);

  localparam logic [15:0] P_DAC_RIDX = 16'h03C7;
  localparam logic [15:0] P_DAC_WIDX = 16'h03C8;
  localparam logic [15:0] P_DAC_DATA = 16'h03C9;
  localparam logic [15:0] P_CRTC_IDX = 16'h03D4;
  localparam logic [15:0] P_CRTC_DAT = 16'h03D5;
  localparam logic [15:0] P_STATUS   = 16'h03DA;

  // Palette read engine: FETCH covers the RAM's one-cycle read latency, LATCH captures the entry.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH} dac_state_t;

  // Palette stores 8-bit channels; the CPU side speaks 6-bit, so replicate the top bits.
  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  dac_state_t  state_q, state_d;
  logic [7:0]  port_out_q, port_out_d;
  logic        dac_we_q, dac_we_d;
  logic [7:0]  dac_addr_q, dac_addr_d;
  logic [31:0] dac_wd_q, dac_wd_d;
  logic [10:0] cursor_q, cursor_d;
  logic [5:0]  shape_lo_q, shape_lo_d;
  logic [4:0]  shape_hi_q, shape_hi_d;
  logic [1:0]  videomode_q, videomode_d;
  logic [7:0]  widx_q, widx_d;
  logic [7:0]  ridx_q, ridx_d;
  logic [1:0]  phase_q, phase_d;
  logic        dir_rd_q, dir_rd_d;     // 1 = last index write went to 3C7
  logic [7:0]  crtc_idx_q, crtc_idx_d;
  logic [5:0]  red_q, red_d;
  logic [5:0]  grn_q, grn_d;
  logic [23:0] rbuf_q, rbuf_d;

  logic        wr_acc;
  logic        rd_acc;
  logic [7:0]  crtc_rdata;
  logic [7:0]  rd_comp;
  logic        dac_rd_unused;

  // Alpha byte of the palette word carries nothing for this port.
  assign dac_rd_unused = ^dac_rd[31:24];

  assign port_ready = (state_q == S_IDLE);
  // A write wins over a simultaneous read; nothing is accepted while a fetch is running.
  assign wr_acc     = port_write && port_ready;
  assign rd_acc     = port_read && port_ready && !port_write;

  // CRTC read-back: mapped fields zero-extended, unmapped indices read as zero.
  always_comb begin
    crtc_rdata = 8'h00;
    if (crtc_idx_q == 8'h0A)        crtc_rdata = {2'b00, shape_lo_q};
    else if (crtc_idx_q == 8'h0B)   crtc_rdata = {3'b000, shape_hi_q};
    else if (crtc_idx_q == 8'h0E)   crtc_rdata = {5'b00000, cursor_q[10:8]};
    else if (crtc_idx_q == 8'h0F)   crtc_rdata = cursor_q[7:0];
    else if (crtc_idx_q == MODE_INDEX) crtc_rdata = {6'b000000, videomode_q};
  end

  // Current 6-bit component of the read buffer selected by the phase counter.
  always_comb begin
    case (phase_q)
      2'd0:    rd_comp = {2'b00, rbuf_q[23:18]};
      2'd1:    rd_comp = {2'b00, rbuf_q[15:10]};
      default: rd_comp = {2'b00, rbuf_q[7:2]};
    endcase
  end

  // Next-state for the fetch FSM, port decode, palette and CRTC registers.
  always_comb begin
    state_d     = state_q;
    port_out_d  = port_out_q;
    dac_we_d    = 1'b0;
    dac_addr_d  = dac_addr_q;
    dac_wd_d    = dac_wd_q;
    cursor_d    = cursor_q;
    shape_lo_d  = shape_lo_q;
    shape_hi_d  = shape_hi_q;
    videomode_d = videomode_q;
    widx_d      = widx_q;
    ridx_d      = ridx_q;
    phase_d     = phase_q;
    dir_rd_d    = dir_rd_q;
    crtc_idx_d  = crtc_idx_q;
    red_d       = red_q;
    grn_d       = grn_q;
    rbuf_d      = rbuf_q;

    case (state_q)
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        rbuf_d  = dac_rd[23:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_acc) begin
      case (port_addr)
        P_DAC_RIDX: begin
          ridx_d     = port_in;
          phase_d    = 2'd0;
          dir_rd_d   = 1'b1;
          dac_addr_d = port_in;
          state_d    = S_FETCH;
        end
        P_DAC_WIDX: begin
          widx_d   = port_in;
          phase_d  = 2'd0;
          dir_rd_d = 1'b0;
        end
        P_DAC_DATA: begin
          if (!dir_rd_q) begin
            case (phase_q)
              2'd0: begin
                red_d   = port_in[5:0];
                phase_d = 2'd1;
              end
              2'd1: begin
                grn_d   = port_in[5:0];
                phase_d = 2'd2;
              end
              default: begin
                dac_we_d   = 1'b1;
                dac_addr_d = widx_q;
                dac_wd_d   = {8'h00, expand6(red_q), expand6(grn_q), expand6(port_in[5:0])};
                widx_d     = widx_q + 8'd1;
                phase_d    = 2'd0;
              end
            endcase
          end
        end
        P_CRTC_IDX: crtc_idx_d = port_in;
        P_CRTC_DAT: begin
          if (crtc_idx_q == 8'h0A)           shape_lo_d     = port_in[5:0];
          else if (crtc_idx_q == 8'h0B)      shape_hi_d     = port_in[4:0];
          else if (crtc_idx_q == 8'h0E)      cursor_d[10:8] = port_in[2:0];
          else if (crtc_idx_q == 8'h0F)      cursor_d[7:0]  = port_in;
          else if (crtc_idx_q == MODE_INDEX) videomode_d    = port_in[1:0];
        end
        default: ;
      endcase
    end else if (rd_acc) begin
      case (port_addr)
        P_DAC_RIDX: port_out_d = dir_rd_q ? 8'h03 : 8'h00;
        P_DAC_WIDX: port_out_d = widx_q;
        P_DAC_DATA: begin
          port_out_d = rd_comp;
          // Only the read direction walks the triplet; the B read refills the buffer.
          if (dir_rd_q) begin
            if (phase_q == 2'd2) begin
              phase_d    = 2'd0;
              ridx_d     = ridx_q + 8'd1;
              dac_addr_d = ridx_q + 8'd1;
              state_d    = S_FETCH;
            end else begin
              phase_d = phase_q + 2'd1;
            end
          end
        end
        P_CRTC_IDX: port_out_d = crtc_idx_q;
        P_CRTC_DAT: port_out_d = crtc_rdata;
        P_STATUS:   port_out_d = {4'b0000, vs, 2'b00, vs | ~hs};
        default:    port_out_d = 8'hFF;
      endcase
    end
  end

  // State register; reset abandons any fetch or half-written triplet.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      port_out_q  <= 8'hFF;
      dac_we_q    <= 1'b0;
      dac_addr_q  <= 8'h00;
      dac_wd_q    <= 32'h0;
      cursor_q    <= 11'h000;
      shape_lo_q  <= CURSOR_LO_RST;
      shape_hi_q  <= CURSOR_HI_RST;
      videomode_q <= 2'd0;
      widx_q      <= 8'h00;
      ridx_q      <= 8'h00;
      phase_q     <= 2'd0;
      dir_rd_q    <= 1'b0;
      crtc_idx_q  <= 8'h00;
      red_q       <= 6'h00;
      grn_q       <= 6'h00;
      rbuf_q      <= 24'h0;
    end else begin
      state_q     <= state_d;
      port_out_q  <= port_out_d;
      dac_we_q    <= dac_we_d;
      dac_addr_q  <= dac_addr_d;
      dac_wd_q    <= dac_wd_d;
      cursor_q    <= cursor_d;
      shape_lo_q  <= shape_lo_d;
      shape_hi_q  <= shape_hi_d;
      videomode_q <= videomode_d;
      widx_q      <= widx_d;
      ridx_q      <= ridx_d;
      phase_q     <= phase_d;
      dir_rd_q    <= dir_rd_d;
      crtc_idx_q  <= crtc_idx_d;
      red_q       <= red_d;
      grn_q       <= grn_d;
      rbuf_q      <= rbuf_d;
    end
  end

  assign port_out        = port_out_q;
  assign dac_we          = dac_we_q;
  assign dac_addr        = dac_addr_q;
  assign dac_wd          = dac_wd_q;
  assign cursor          = cursor_q;
  assign cursor_shape_lo = shape_lo_q;
  assign cursor_shape_hi = shape_hi_q;
  assign videomode       = videomode_q;

endmodule

// File: tb/tb_vga_ports.sv
// Bench for vga_ports: directed port transactions against a transaction-level model.
// Inputs change 1 time unit after a rising edge; outputs are compared on the falling edge.
// The bench also plays the palette RAM with one cycle of read latency.
module tb_vga_ports;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] port_addr = 16'h0;
  logic [7:0]  port_in = 8'h0;
  logic        port_write = 1'b0;
  logic        port_read = 1'b0;
  logic [7:0]  port_out;
  logic        port_ready;
  logic        hs = 1'b1;
  logic        vs = 1'b0;
  logic        dac_we;
  logic [7:0]  dac_addr;
  logic [31:0] dac_wd;
  logic [31:0] dac_rd = 32'h0;
  logic [10:0] cursor;
  logic [5:0]  cursor_shape_lo;
  logic [4:0]  cursor_shape_hi;
  logic [1:0]  videomode;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  vga_ports dut (
    .clock(clock), .reset(reset),
    .port_addr(port_addr), .port_in(port_in),
    .port_write(port_write), .port_read(port_read),
    .port_out(port_out), .port_ready(port_ready),
    .hs(hs), .vs(vs),
    .dac_we(dac_we), .dac_addr(dac_addr), .dac_wd(dac_wd), .dac_rd(dac_rd),
    .cursor(cursor), .cursor_shape_lo(cursor_shape_lo),
    .cursor_shape_hi(cursor_shape_hi), .videomode(videomode)
  );

  // Initial palette contents, known to both the RAM and the model.
  function automatic logic [31:0] init_pal(input logic [7:0] a);
    if (a == 8'h10) return 32'h00FC8004;
    return {8'h00, a, ~a, a ^ 8'h5A};
  endfunction

  // Palette RAM: synchronous write, registered read.
  logic [31:0] ram [256];
  bit          ramw [256];
  always @(posedge clock) begin
    if (dac_we === 1'b1) begin
      ram[dac_addr]  <= dac_wd;
      ramw[dac_addr] <= 1'b1;
    end
    dac_rd <= ramw[dac_addr] ? ram[dac_addr] : init_pal(dac_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [7:0]  m_out, m_addr, m_widx, m_ridx, m_crtc;
  logic        m_we, m_dir;
  logic [31:0] m_wd;
  logic [10:0] m_cursor;
  logic [5:0]  m_lo;
  logic [4:0]  m_hi;
  logic [1:0]  m_vm;
  logic [23:0] m_rbuf;
  logic [5:0]  m_comp [3];
  logic [31:0] mpal [256];
  int          m_phase, m_busy;

  function automatic logic [7:0] x8(input logic [5:0] v);
    logic [7:0] w;
    w = ({2'b00, v} << 2) | ({2'b00, v} >> 4);
    return w;
  endfunction

  function automatic logic [7:0] crtc_read();
    case (m_crtc)
      8'h0A:   return {2'b00, m_lo};
      8'h0B:   return {3'b000, m_hi};
      8'h0E:   return {5'b00000, m_cursor[10:8]};
      8'h0F:   return m_cursor[7:0];
      8'h30:   return {6'b000000, m_vm};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_out = 8'hFF; m_we = 1'b0; m_addr = 8'h00; m_wd = 32'h0;
    m_cursor = 11'h0; m_lo = 6'd14; m_hi = 5'd15; m_vm = 2'd0;
    m_widx = 8'h00; m_ridx = 8'h00; m_phase = 0; m_dir = 1'b0;
    m_crtc = 8'h00; m_rbuf = 24'h0; m_busy = 0;
  endtask

  // Effect of one clock edge given the strobes presented in front of it.
  task automatic model_step(input bit wr, input bit rd, input logic [15:0] a, input logic [7:0] d);
    m_we = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (wr) begin
      case (a)
        16'h03C7: begin
          m_ridx = d; m_phase = 0; m_dir = 1'b1; m_addr = d;
          m_rbuf = mpal[d][23:0]; m_busy = 2;
        end
        16'h03C8: begin m_widx = d; m_phase = 0; m_dir = 1'b0; end
        16'h03C9: begin
          if (!m_dir) begin
            m_comp[m_phase] = d[5:0];
            m_phase++;
            if (m_phase == 3) begin
              m_wd = {8'h00, x8(m_comp[0]), x8(m_comp[1]), x8(m_comp[2])};
              m_we = 1'b1; m_addr = m_widx; mpal[m_widx] = m_wd;
              m_widx++; m_phase = 0;
            end
          end
        end
        16'h03D4: m_crtc = d;
        16'h03D5: begin
          case (m_crtc)
            8'h0A: m_lo = d[5:0];
            8'h0B: m_hi = d[4:0];
            8'h0E: m_cursor[10:8] = d[2:0];
            8'h0F: m_cursor[7:0] = d;
            8'h30: m_vm = d[1:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end else if (rd) begin
      case (a)
        16'h03C7: m_out = m_dir ? 8'h03 : 8'h00;
        16'h03C8: m_out = m_widx;
        16'h03C9: begin
          m_out = {2'b00, m_rbuf[23 - 8*m_phase -: 6]};
          if (m_dir) begin
            m_phase++;
            if (m_phase == 3) begin
              m_phase = 0; m_ridx++; m_addr = m_ridx;
              m_rbuf = mpal[m_ridx][23:0]; m_busy = 2;
            end
          end
        end
        16'h03D4: m_out = m_crtc;
        16'h03D5: m_out = crtc_read();
        16'h03DA: m_out = {4'b0000, vs, 2'b00, vs | ~hs};
        default:  m_out = 8'hFF;
      endcase
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_port_out", {24'h0, port_out}, {24'h0, m_out});
      chk("cyc_port_ready", {31'h0, port_ready}, {31'h0, m_busy == 0});
      chk("cyc_dac_we", {31'h0, dac_we}, {31'h0, m_we});
      chk("cyc_dac_addr", {24'h0, dac_addr}, {24'h0, m_addr});
      chk("cyc_dac_wd", dac_wd, m_wd);
      chk("cyc_cursor", {21'h0, cursor}, {21'h0, m_cursor});
      chk("cyc_shape_lo", {26'h0, cursor_shape_lo}, {26'h0, m_lo});
      chk("cyc_shape_hi", {27'h0, cursor_shape_hi}, {27'h0, m_hi});
      chk("cyc_videomode", {30'h0, videomode}, {30'h0, m_vm});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit wr, input bit rd, input logic [15:0] a, input logic [7:0] d);
    port_write = wr; port_read = rd; port_addr = a; port_in = d;
    @(posedge clock);
    #1;
    model_step(wr, rd, a, d);
    port_write = 1'b0; port_read = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [15:0] a);
    cyc(1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mpal[i] = init_pal(i[7:0]);
    model_reset();
    repeat (2) @(posedge clock);
    do_reset();
    chk_en = 1'b1;

    chk("rst_port_out", {24'h0, port_out}, 32'hFF);
    chk("rst_ready", {31'h0, port_ready}, 32'h1);
    chk("rst_dac_we", {31'h0, dac_we}, 32'h0);
    chk("rst_shape_lo", {26'h0, cursor_shape_lo}, 32'h0E);
    chk("rst_shape_hi", {27'h0, cursor_shape_hi}, 32'h0F);
    chk("rst_cursor", {21'h0, cursor}, 32'h0);
    chk("rst_videomode", {30'h0, videomode}, 32'h0);

    wr(16'h03D4, 8'h0A); rd(16'h03D5);
    chk("crtc_0A_read", {24'h0, port_out}, 32'h0E);
    wr(16'h03D4, 8'h0B); rd(16'h03D5);
    chk("crtc_0B_read", {24'h0, port_out}, 32'h0F);
    rd(16'h1234);
    chk("unmapped_read", {24'h0, port_out}, 32'hFF);

    // Palette write at index 255, then wrap of the write index.
    wr(16'h03C8, 8'hFF);
    wr(16'h03C9, 8'h3F); wr(16'h03C9, 8'h00);
    chk("no_early_we", {31'h0, dac_we}, 32'h0);
    wr(16'h03C9, 8'h15);
    chk("wr_dac_we", {31'h0, dac_we}, 32'h1);
    chk("wr_dac_addr", {24'h0, dac_addr}, 32'hFF);
    chk("wr_dac_wd", dac_wd, 32'h00FF0055);
    idle();
    chk("we_one_cycle", {31'h0, dac_we}, 32'h0);
    rd(16'h03C8);
    chk("widx_wrap", {24'h0, port_out}, 32'h00);

    // Palette read at index 0x10 with automatic fetch of 0x11.
    wr(16'h03C7, 8'h10);
    chk("fetch_ready_c1", {31'h0, port_ready}, 32'h0);
    chk("fetch_addr", {24'h0, dac_addr}, 32'h10);
    idle();
    chk("fetch_ready_c2", {31'h0, port_ready}, 32'h0);
    idle();
    chk("fetch_ready_c3", {31'h0, port_ready}, 32'h1);
    rd(16'h03C7);
    chk("ridx_dir", {24'h0, port_out}, 32'h03);
    rd(16'h03C9); chk("rd_R", {24'h0, port_out}, 32'h3F);
    rd(16'h03C9); chk("rd_G", {24'h0, port_out}, 32'h20);
    rd(16'h03C9); chk("rd_B", {24'h0, port_out}, 32'h01);
    chk("auto_ready", {31'h0, port_ready}, 32'h0);
    chk("auto_addr", {24'h0, dac_addr}, 32'h11);
    wr(16'h03D4, 8'h0A);   // dropped: fetch in progress
    idle();
    chk("auto_ready_back", {31'h0, port_ready}, 32'h1);
    rd(16'h03D4);
    chk("busy_write_dropped", {24'h0, port_out}, 32'h0B);
    rd(16'h03C9);
    chk("auto_fetch_R", {24'h0, port_out}, 32'h04);

    // CRTC cursor and mode.
    wr(16'h03D4, 8'h0E); wr(16'h03D5, 8'h07);
    wr(16'h03D4, 8'h0F); wr(16'h03D5, 8'hD0);
    chk("cursor_2000", {21'h0, cursor}, 32'h7D0);
    wr(16'h03D4, 8'h30); wr(16'h03D5, 8'h02);
    chk("videomode_2", {30'h0, videomode}, 32'h2);
    rd(16'h03D5);
    chk("mode_read", {24'h0, port_out}, 32'h02);
    wr(16'h03D4, 8'h05); wr(16'h03D5, 8'h3C); rd(16'h03D5);
    chk("crtc_unmapped", {24'h0, port_out}, 32'h00);

    // Simultaneous write and read: write wins, port_out holds.
    rd(16'h1234);
    cyc(1'b1, 1'b1, 16'h03C8, 8'h05);
    chk("wr_rd_hold", {24'h0, port_out}, 32'hFF);
    rd(16'h03C8);
    chk("wr_rd_widx", {24'h0, port_out}, 32'h05);

    // Reset in the middle of a triplet.
    wr(16'h03C9, 8'h2A); wr(16'h03C9, 8'h11);
    do_reset();
    chk("mid_rst_we", {31'h0, dac_we}, 32'h0);
    wr(16'h03C9, 8'h01); wr(16'h03C9, 8'h02); wr(16'h03C9, 8'h03);
    chk("post_rst_we", {31'h0, dac_we}, 32'h1);
    chk("post_rst_addr", {24'h0, dac_addr}, 32'h00);
    chk("post_rst_wd", dac_wd, 32'h0004080C);

    // Input status.
    hs = 1'b1; vs = 1'b1; rd(16'h03DA);
    chk("status_vs", {24'h0, port_out}, 32'h09);
    hs = 1'b0; vs = 1'b0; rd(16'h03DA);
    chk("status_hs", {24'h0, port_out}, 32'h01);
    hs = 1'b1; vs = 1'b0; rd(16'h03DA);
    chk("status_none", {24'h0, port_out}, 32'h00);

    idle(); idle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
